// File: rtl/data_unpack_pkg.sv
// data_unpack_pkg: widths and chunk planning for the 32-to-7 unpacker.
// Honours DATA_UNPACK_EOP_FLUSH_EN: when defined, the residual is flushed as a padded chunk at eop.
package data_unpack_pkg;
    localparam int IN_W  = 32;
    localparam int OUT_W = 7;
    localparam int BUF_W = IN_W + OUT_W - 1;
    localparam int RES_W = $clog2(OUT_W);
    localparam int CNT_W = $clog2((IN_W + OUT_W - 1) / OUT_W + 2);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [RES_W-1:0] res;
    } plan_t;

    // Chunks produced by one word and the residual it leaves, given the residual before it.
    function automatic plan_t chunk_plan(input logic [RES_W-1:0] r, input logic eop);
        int total;
        int full;
        int rem;
        plan_t p;
        total = int'(r) + IN_W;
        full  = total / OUT_W;
        rem   = total % OUT_W;
`ifdef DATA_UNPACK_EOP_FLUSH_EN
        if (eop && rem != 0) full = full + 1;
`endif
        p.cnt = CNT_W'(full);
        p.res = eop ? '0 : RES_W'(rem);
        return p;
    endfunction
endpackage

// File: rtl/unpack_bitbuf.sv
// unpack_bitbuf: residual-plus-word shift buffer; chunk is the next LSB-first slice.
module unpack_bitbuf import data_unpack_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [RES_W-1:0] res,
    input  logic [IN_W-1:0]  data_in,
    output logic [OUT_W-1:0] chunk
);
    logic [BUF_W-1:0] bits;
    logic [BUF_W-1:0] keep;
    logic [BUF_W-1:0] full;

    // Keep only the live residual bits and append the new word above them.
    always_comb begin
        keep  = (BUF_W'(1) << res) - BUF_W'(1);
        full  = (bits & keep) | (BUF_W'(data_in) << res);
        chunk = load ? full[OUT_W-1:0] : bits[OUT_W-1:0];
    end

    // The presented chunk leaves the buffer as soon as it is taken into the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bits <= '0;
        else if (load) bits <= full >> OUT_W;
        else if (shift) bits <= bits >> OUT_W;
    end
endmodule

// File: rtl/data_unpack.sv
// data_unpack: splits 32-bit packet words into a gap-free LSB-first 7-bit chunk stream.
// Build option DATA_UNPACK_EOP_FLUSH_EN selects flushing of the residual at end of packet.
module data_unpack import data_unpack_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [IN_W-1:0]  data_in,
    input  logic             sop_in,
    input  logic             eop_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [OUT_W-1:0] data_out,
    output logic             sop_out,
    output logic             eop_out
);
    logic             accept;
    logic             shift;
    logic [CNT_W-1:0] pend;
    logic [RES_W-1:0] res;
    logic [RES_W-1:0] res_use;
    logic             eop_word;
    logic [OUT_W-1:0] chunk;
    plan_t            plan;

    assign accept  = valid_in && ready_out;
    assign shift   = !accept && pend > CNT_W'(1);
    assign res_use = sop_in ? '0 : res;
    assign plan    = chunk_plan(res_use, eop_in);

    unpack_bitbuf u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (shift),
        .res     (res_use),
        .data_in (data_in),
        .chunk   (chunk)
    );

    // Present one chunk per cycle; ready rises while the last pending chunk is on the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= '0;
            res       <= '0;
            eop_word  <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            ready_out <= 1'b0;
        end else if (accept) begin
            pend      <= plan.cnt;
            res       <= plan.res;
            eop_word  <= eop_in;
            valid_out <= 1'b1;
            data_out  <= chunk;
            sop_out   <= sop_in;
            eop_out   <= eop_in && plan.cnt == CNT_W'(1);
            ready_out <= plan.cnt <= CNT_W'(1);
        end else if (pend > CNT_W'(1)) begin
            pend      <= pend - CNT_W'(1);
            data_out  <= chunk;
            sop_out   <= 1'b0;
            eop_out   <= eop_word && pend == CNT_W'(2);
            ready_out <= pend == CNT_W'(2);
        end else begin
            pend      <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            ready_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_data_unpack.sv
// tb_data_unpack: table vectors, corner sequences and random packets against a bit-queue model.
module tb_data_unpack;
    import data_unpack_pkg::*;

`ifdef DATA_UNPACK_EOP_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    typedef struct {
        logic [6:0] d;
        bit         s;
        bit         e;
        bit         r;
        int         cyc;
    } chunk_t;

    typedef struct {
        logic [31:0] w;
        logic [6:0]  first;
        int          n_fl;
        logic [6:0]  last_fl;
        int          n_nf;
        logic [6:0]  last_nf;
    } vec_t;

    typedef logic [31:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic        sop_in = 1'b0;
    logic        eop_in = 1'b0;
    logic        ready_out;
    logic        valid_out;
    logic [6:0]  data_out;
    logic        sop_out;
    logic        eop_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int inv_bad = 0;
    int acc_cyc = 0;
    chunk_t got[$];
    chunk_t exp_q[$];

    data_unpack dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        chunk_t c;
        if (rst) begin
            if (valid_out) begin
                c = '{data_out, sop_out, eop_out, ready_out, cyc};
                got.push_back(c);
            end else if (sop_out || eop_out) begin
                inv_bad++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, g, e);
        end
    endtask

    task automatic send(input logic [31:0] w, input bit s, input bit e);
        int n = 0;
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = w;
        sop_in   = s;
        eop_in   = e;
        while (!ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got=not_ready want=ready");
        end
        @(posedge clk);
        #1 acc_cyc = cyc;
    endtask

    task automatic stop_in();
        @(negedge clk);
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        stop_in();
        while ((valid_out || !ready_out) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL %s_drain_timeout: got=busy want=idle", nm);
        end
        chk({nm, "_framing"}, inv_bad, 0);
        inv_bad = 0;
    endtask

    // Reference: a packet is one long bit stream cut into 7-bit groups from bit 0 upward.
    task automatic model_pkt(input word_q_t ws);
        bit     bq[$];
        chunk_t c;
        bit     first = 1'b1;
        foreach (ws[k])
            for (int i = 0; i < 32; i++) bq.push_back(ws[k][i]);
        while (bq.size() >= 7 || (FLUSH && bq.size() > 0)) begin
            c.d = '0;
            for (int i = 0; i < 7; i++)
                if (bq.size() > 0) c.d[i] = bq.pop_front();
            c.s   = first;
            c.e   = !(bq.size() >= 7 || (FLUSH && bq.size() > 0));
            c.r   = 1'b0;
            c.cyc = 0;
            first = 1'b0;
            exp_q.push_back(c);
        end
    endtask

    task automatic send_pkt(input word_q_t ws, input bit gaps);
        foreach (ws[k]) begin
            send(ws[k], k == 0, k == ws.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                stop_in();
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
        end
        model_pkt(ws);
    endtask

    task automatic cmp(input string nm);
        int b0 = bad;
        chk({nm, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size() && bad == b0; i++) begin
            chk({nm, "_data"}, got[i].d, exp_q[i].d);
            chk({nm, "_sop"}, got[i].s, exp_q[i].s);
            chk({nm, "_eop"}, got[i].e, exp_q[i].e);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t    vt[5];
        word_q_t ws;
        int      n;
        vt[0] = '{32'h12345678, 7'h78, 5, 7'h01, 4, 7'h11};
        vt[1] = '{32'hFFFFFFFF, 7'h7F, 5, 7'h0F, 4, 7'h7F};
        vt[2] = '{32'h00000000, 7'h00, 5, 7'h00, 4, 7'h00};
        vt[3] = '{32'h80000001, 7'h01, 5, 7'h08, 4, 7'h00};
        vt[4] = '{32'hA5A5A5A5, 7'h25, 5, 7'h0A, 4, 7'h2D};

        repeat (3) @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_sop", sop_out, 0);
        chk("rst_eop", eop_out, 0);
        chk("rst_ready", ready_out, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", ready_out, 1);

        for (int i = 0; i < 5; i++) begin
            send(vt[i].w, 1'b1, 1'b1);
            drain("vec");
            n = FLUSH ? vt[i].n_fl : vt[i].n_nf;
            chk("vec_count", got.size(), n);
            if (got.size() > 0) begin
                chk("vec_latency", got[0].cyc, acc_cyc);
                chk("vec_first", got[0].d, vt[i].first);
                chk("vec_first_sop", got[0].s, 1);
                chk("vec_first_ready", got[0].r, 0);
                chk("vec_last", got[got.size()-1].d, FLUSH ? vt[i].last_fl : vt[i].last_nf);
                chk("vec_last_eop", got[got.size()-1].e, 1);
                chk("vec_last_ready", got[got.size()-1].r, 1);
                chk("vec_mid_eop", got[0].e, 0);
            end
            got.delete();
        end

        ws = '{32'hFFFFFFFF, 32'h00000000};
        send_pkt(ws, 1'b0);
        drain("ff00");
        chk("ff00_count_const", got.size(), FLUSH ? 10 : 9);
        cmp("ff00");

        ws.delete();
        for (int i = 0; i < 7; i++) ws.push_back($urandom);
        send_pkt(ws, 1'b0);
        drain("seven");
        chk("seven_count", got.size(), 32);
        if (got.size() == 32) chk("seven_gapfree", got[31].cyc - got[0].cyc, 31);
        if (got.size() > 0) chk("seven_last_eop", got[got.size()-1].d, ws[6][31:25]);
        cmp("seven");

        send(32'hFFFFFFFF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        sop_in = 1'b0;
        #1;
        chk("midrst_valid", valid_out, 0);
        chk("midrst_data", data_out, 0);
        chk("midrst_sop", sop_out, 0);
        chk("midrst_ready", ready_out, 0);
        @(negedge clk);
        rst = 1'b1;
        got.delete();
        @(negedge clk);
        chk("midrst_ready_after", ready_out, 1);
        chk("midrst_idle", valid_out, 0);
        ws = '{32'h12345678};
        send_pkt(ws, 1'b0);
        drain("after_rst");
        cmp("after_rst");

        for (int p = 0; p < 40; p++) begin
            ws.delete();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) ws.push_back($urandom);
            send_pkt(ws, 1'b1);
        end
        drain("rand");
        cmp("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_unpack.md
# data_unpack

Streaming width converter that splits 32-bit input words into a continuous LSB-first stream of 7-bit output chunks. It sits between a 32-bit packetised producer and a 7-bit consumer. Framing is carried through: sop/eop are translated to the first and last output chunk of a packet. Residual bits are carried across words within a packet and flushed at end of packet.

## Interface
- IN_W, 32, input word width.
- OUT_W, 7, output chunk width; must satisfy OUT_W < IN_W.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid_in  input  1  input word valid.
- data_in  input  IN_W  input word.
- sop_in  input  1  word is the first of a packet; qualified by valid_in.
- eop_in  input  1  word is the last of a packet; qualified by valid_in.
- ready_out  output  1  block can accept a word this cycle.
- valid_out  output  1  data_out holds a chunk; no backpressure, consumer must take it.
- data_out  output  OUT_W  output chunk.
- sop_out  output  1  first chunk of a packet.
- eop_out  output  1  last chunk of a packet.

## Operation
- A word is accepted on a rising edge where valid_in && ready_out. valid_in without ready_out is ignored; the source must hold valid_in/data_in until accepted.
- Internal bit buffer holds residual r bits (0..OUT_W-1) plus the accepted word. New bits are appended above the residual, giving total = r + IN_W bits.
- Chunks are taken LSB-first: chunk k = buffer[7k+6 : 7k]. Emitted chunks = floor(total/7). New residual = total mod 7.
- For 32/7 the sequence of r is 0→4→1→5→2→6→3→0, giving 4 or 5 chunks per word.
- sop_in: residual is discarded before appending; r = 0. The first chunk from that word carries sop_out=1.
- eop_in: if the final residual is > 0, one extra chunk is emitted, holding the residual zero-padded in the MSBs. eop_out=1 on the last chunk of the word. Residual then becomes 0. Maximum is 6 chunks per word.
- sop_out and eop_out are asserted only together with valid_out. Both may be set on a single-word packet, on different chunks.
- sop_in and eop_in on the same word means a single-word packet.

## Timing
- Reset (rst=0): valid_out, data_out, sop_out, eop_out, residual and pending count all go to 0; ready_out=0. ready_out rises in the first cycle after rst deasserts.
- Latency: the first chunk is presented in the cycle after the acceptance edge. Chunks follow on consecutive cycles, one per cycle, with no gaps.
- ready_out is registered. It is 1 when no chunk is pending, or when the chunk currently presented is the last pending one.
- Consequence: a new word may be accepted on the edge that retires the last chunk. Back-to-back words produce a gap-free output stream.
- ready_out=0 in the cycle after an acceptance whenever ≥2 chunks are pending. This is always the case, since every word yields ≥4 chunks.
- Reset asserted mid-word: pending chunks are dropped and all state is cleared asynchronously.

## Configuration
- DATA_UNPACK_EOP_FLUSH_EN defined: residual bits are flushed as a zero-padded chunk at eop, as described above.
- DATA_UNPACK_EOP_FLUSH_EN undefined: the residual at eop is silently discarded. eop_out is set on the last full chunk, and r resets to 0.

## Structure
- Package data_unpack_pkg holds:
  - IN_W and OUT_W defaults;
  - RES_W = $clog2(OUT_W) as the residual-count width;
  - CNT_W sized for the max chunk count (6);
  - the chunk-count/residual computation as a function.
- One sub-module, unpack_bitbuf, holds the shift buffer (width IN_W+OUT_W-1) with append/shift-out ports. data_unpack holds the handshake, counters and framing.

## Test plan
- Single word 0x12345678, sop=1, eop=1 → chunks 0x78, 0x2C, 0x51, 0x11, 0x01; sop_out on first chunk, eop_out on 0x01; ready_out high again by the last chunk.
- 0xFFFFFFFF (sop) then 0x00000000 (eop) → 0x7F ×4, 0x0F, 0x00 ×5 (10 chunks); eop_out only on the 10th chunk.
- Seven words of one packet (sop first, eop last), back-to-back valid_in → exactly 32 chunks, r returns to 0, no flush chunk, valid_out continuous with no idle cycles.
- valid_in held while ready_out=0 → the word is not consumed until ready_out=1; no duplicate chunks; the input stream reconstructed from chunks equals the words sent.
- rst pulsed low during chunk 2 of a word → all outputs 0 immediately; after release ready_out=1, and the next sop word starts at r=0.
- With DATA_UNPACK_EOP_FLUSH_EN undefined, 0x12345678 sop+eop → 4 chunks; eop_out on 0x11; no 0x01 chunk.
